// File: rtl/eth_mac_tx_framer.sv
// eth_mac_tx_framer: turns frames from the TX prefetch FIFO into a GMII stream (preamble, SFD, data, [pad], FCS, IFG).
// Latency: tx_start sampled at cycle N -> first 0x55 on gmii_txd at N+1; all GMII outputs are registered.
// Backpressure: none toward GMII; an empty FIFO mid-frame is an underrun (one tx_er cycle, then drain to frame end).
// Ports: tx_start/tx_len/tx_ready/tx_done/tx_err  - frame request and status
//        fifo_rd_en/fifo_rd_vld/fifo_rd_data       - pop interface of the prefetch FIFO
//        gmii_tx_en/gmii_tx_er/gmii_txd            - registered GMII transmit outputs
// Build option: define ETH_MAC_TX_PAD_EN to zero-pad frames shorter than MIN_FRAME bytes before the FCS.
module eth_mac_tx_framer #(
  parameter int LEN_WIDTH  = 11,
  parameter int MAX_LEN    = 1514,
  parameter int MIN_FRAME  = 60,
  parameter int IFG_CYCLES = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [LEN_WIDTH-1:0] tx_len,
  output logic                 tx_ready,
  output logic                 tx_done,
  output logic                 tx_err,
  output logic                 fifo_rd_en,
  input  logic                 fifo_rd_vld,
  input  logic [7:0]           fifo_rd_data,
  output logic                 gmii_tx_en,
  output logic                 gmii_tx_er,
  output logic [7:0]           gmii_txd
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG, S_DRAIN
  } state_t;

`ifdef ETH_MAC_TX_PAD_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif

  localparam logic [LEN_WIDTH-1:0] MAX_LEN_L = LEN_WIDTH'(MAX_LEN);
  localparam logic [LEN_WIDTH-1:0] MIN_L     = LEN_WIDTH'(MIN_FRAME);
  localparam logic [LEN_WIDTH-1:0] IFG_LAST  = LEN_WIDTH'(IFG_CYCLES - 1);
  // The first preamble byte is loaded on the IDLE->PRE edge, so PRE itself
  // only has to produce the remaining six.
  localparam logic [LEN_WIDTH-1:0] PRE_LAST  = LEN_WIDTH'(5);

  state_t               state, state_nxt;
  logic [LEN_WIDTH-1:0] cnt, cnt_nxt, cnt_inc;
  logic [LEN_WIDTH-1:0] len, len_nxt;
  logic [31:0]          crc, crc_nxt, fcs;
  logic                 frame_ok, frame_ok_nxt;
  logic                 pad_needed;
  logic [7:0]           txd_nxt;
  logic                 tx_en_nxt, tx_er_nxt, tx_err_nxt;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign cnt_inc    = cnt + LEN_WIDTH'(1);
  assign fcs        = ~crc;
  assign pad_needed = PAD_ON && (len < MIN_L);
  assign tx_ready   = (state == S_IDLE);
  assign fifo_rd_en = ((state == S_DATA) || (state == S_DRAIN)) && fifo_rd_vld;
  assign tx_done    = (state == S_IFG) && (cnt == IFG_LAST) && frame_ok;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    len_nxt      = len;
    crc_nxt      = crc;
    frame_ok_nxt = frame_ok;
    txd_nxt      = 8'h00;
    tx_en_nxt    = 1'b0;
    tx_er_nxt    = 1'b0;
    tx_err_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (tx_start) begin
          if ((tx_len != '0) && (tx_len <= MAX_LEN_L)) begin
            state_nxt    = S_PRE;
            len_nxt      = tx_len;
            cnt_nxt      = '0;
            crc_nxt      = 32'hFFFFFFFF;
            frame_ok_nxt = 1'b1;
            txd_nxt      = 8'h55;
            tx_en_nxt    = 1'b1;
          end else begin
            tx_err_nxt = 1'b1;
          end
        end
      end
      S_PRE: begin
        txd_nxt   = 8'h55;
        tx_en_nxt = 1'b1;
        if (cnt == PRE_LAST) begin
          state_nxt = S_SFD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      S_SFD: begin
        txd_nxt   = 8'hD5;
        tx_en_nxt = 1'b1;
        state_nxt = S_DATA;
        cnt_nxt   = '0;
      end
      S_DATA: begin
        if (fifo_rd_vld) begin
          txd_nxt   = fifo_rd_data;
          tx_en_nxt = 1'b1;
          crc_nxt   = crc_byte(crc, fifo_rd_data);
          cnt_nxt   = cnt_inc;
          if (cnt_inc == len) begin
            if (pad_needed) begin
              state_nxt = S_PAD;       // cnt keeps counting total frame bytes
            end else begin
              state_nxt = S_FCS;
              cnt_nxt   = '0;
            end
          end
        end else begin
          // Underrun: poison the frame on the wire, then drain its tail.
          tx_en_nxt    = 1'b1;
          tx_er_nxt    = 1'b1;
          tx_err_nxt   = 1'b1;
          frame_ok_nxt = 1'b0;
          state_nxt    = S_DRAIN;
        end
      end
`ifdef ETH_MAC_TX_PAD_EN
      S_PAD: begin
        tx_en_nxt = 1'b1;
        crc_nxt   = crc_byte(crc, 8'h00);
        cnt_nxt   = cnt_inc;
        if (cnt_inc == MIN_L) begin
          state_nxt = S_FCS;
          cnt_nxt   = '0;
        end
      end
`endif
      S_FCS: begin
        txd_nxt   = fcs[{cnt[1:0], 3'b000} +: 8];
        tx_en_nxt = 1'b1;
        if (cnt[1:0] == 2'd3) begin
          state_nxt = S_IFG;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      S_IFG: begin
        // The wire goes quiet one cycle after IFG is entered and stays quiet
        // through the following IDLE cycle, giving IFG_CYCLES idle bytes.
        if (cnt == IFG_LAST) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      S_DRAIN: begin
        if (fifo_rd_vld) begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == len) begin
            state_nxt = S_IFG;
            cnt_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      len        <= '0;
      crc        <= 32'hFFFFFFFF;
      frame_ok   <= 1'b0;
      gmii_txd   <= 8'h00;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      tx_err     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      len        <= len_nxt;
      crc        <= crc_nxt;
      frame_ok   <= frame_ok_nxt;
      gmii_txd   <= txd_nxt;
      gmii_tx_en <= tx_en_nxt;
      gmii_tx_er <= tx_er_nxt;
      tx_err     <= tx_err_nxt;
    end
  end

endmodule

// File: tb/tb_eth_mac_tx_framer.sv
// tb_eth_mac_tx_framer: self-checking bench for eth_mac_tx_framer.
// A bench FIFO feeds the DUT; every expected wire byte is queued at frame start and popped by a GMII monitor.
// Table vectors cover accept/reject lengths; hand sequences cover underrun, back-to-back IFG and mid-frame reset.
module tb_eth_mac_tx_framer;

  localparam int LW        = 11;
  localparam int MIN_FRAME = 60;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tx_start = 1'b0;
  logic [LW-1:0] tx_len = '0;
  logic          tx_ready, tx_done, tx_err, fifo_rd_en;
  logic          fifo_rd_vld = 1'b0;
  logic [7:0]    fifo_rd_data = 8'h00;
  logic          gmii_tx_en, gmii_tx_er;
  logic [7:0]    gmii_txd;

  eth_mac_tx_framer dut (
    .clk(clk), .rst(rst),
    .tx_start(tx_start), .tx_len(tx_len),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_err(tx_err),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_vld(fifo_rd_vld), .fifo_rd_data(fifo_rd_data),
    .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er), .gmii_txd(gmii_txd)
  );

  always #4 clk = ~clk;

  typedef struct { logic er; logic [7:0] d; } wb_t;
  typedef struct { int len; logic [7:0] base; logic [7:0] step; bit exp_err; bit exp_done; } vec_t;

  wb_t        exp_q[$];
  logic [7:0] fifo_q[$];
  logic [7:0] cap[$];

  int n_cmp = 0, n_bad = 0;
  int pop_cnt = 0, done_cnt = 0, err_cnt = 0, en_cnt = 0, er_cnt = 0, busy_cnt = 0, er_err_cnt = 0;
  int cyc = 0, last_en_cyc = 0, last_gap = -1;
  logic en_prev = 1'b0;
  logic rd_s = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic wb_t mk(input logic er, input logic [7:0] d);
    wb_t w;
    w.er = er;
    w.d  = d;
    return w;
  endfunction

  function automatic logic [7:0] pay(input logic [7:0] base, input logic [7:0] step, input int i);
    return base + 8'(i) * step;
  endfunction

  // Bit-serial reflected CRC-32 reference.
  function automatic logic [31:0] ref_crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int b = 0; b < 8; b++) begin
      fb = r[0] ^ d[b];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  // Bench FIFO: a pop seen at the negedge is applied just after the next posedge.
  always begin
    @(negedge clk);
    rd_s = fifo_rd_en;
    @(posedge clk);
    #1;
    if (rd_s && !rst && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      pop_cnt++;
    end
    fifo_rd_vld  = (fifo_q.size() != 0);
    fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  end

  // GMII monitor and scoreboard consumer.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (tx_done) done_cnt++;
      if (tx_err) err_cnt++;
      if (gmii_tx_er) er_cnt++;
      if (gmii_tx_er && tx_err) er_err_cnt++;
      if (!tx_ready) busy_cnt++;
      if (gmii_tx_en) begin
        en_cnt++;
        if (!en_prev) last_gap = cyc - last_en_cyc - 1;
        last_en_cyc = cyc;
        cap.push_back(gmii_txd);
        chk("sb_has_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          wb_t e;
          e = exp_q.pop_front();
          chk("wire_tx_er", gmii_tx_er, e.er);
          if (!e.er) chk("wire_txd", gmii_txd, e.d);
        end
      end
    end
    en_prev = gmii_tx_en;
  end

  task automatic clear_counts();
    pop_cnt = 0; done_cnt = 0; err_cnt = 0; en_cnt = 0; er_cnt = 0; busy_cnt = 0; er_err_cnt = 0;
  endtask

  task automatic load_fifo(input int n, input logic [7:0] base, input logic [7:0] step, input int first);
    for (int i = first; i < first + n; i++) fifo_q.push_back(pay(base, step, i));
  endtask

  task automatic expect_frame(input int len, input logic [7:0] base, input logic [7:0] step, output int wl);
    logic [31:0] c;
    logic [7:0]  b;
    int          plen;
    plen = len;
`ifdef ETH_MAC_TX_PAD_EN
    if (plen < MIN_FRAME) plen = MIN_FRAME;
`endif
    for (int i = 0; i < 7; i++) exp_q.push_back(mk(1'b0, 8'h55));
    exp_q.push_back(mk(1'b0, 8'hD5));
    c = 32'hFFFFFFFF;
    for (int i = 0; i < plen; i++) begin
      b = (i < len) ? pay(base, step, i) : 8'h00;
      c = ref_crc_step(c, b);
      exp_q.push_back(mk(1'b0, b));
    end
    c = ~c;
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b0, c[8*i +: 8]));
    wl = 8 + plen + 4;
  endtask

  // Called at a negedge; tx_start is seen by exactly one posedge; returns at the next negedge.
  task automatic start_now(input int len);
    tx_start = 1'b1;
    tx_len   = LW'(len);
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_ready(input int bound);
    int n;
    n = 0;
    while (!tx_ready && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", (n >= bound), 0);
  endtask

  task automatic chk_fcs_123();
    chk("fcs_b0", cap[cap.size()-4], 8'h26);
    chk("fcs_b1", cap[cap.size()-3], 8'h39);
    chk("fcs_b2", cap[cap.size()-2], 8'hF4);
    chk("fcs_b3", cap[cap.size()-1], 8'hCB);
  endtask

  task automatic run_vec(input vec_t v);
    int wl;
    @(negedge clk);
    clear_counts();
    cap.delete();
    if (v.exp_done) begin
      load_fifo(v.len, v.base, v.step, 0);
      expect_frame(v.len, v.base, v.step, wl);
    end else begin
      load_fifo(4, v.base, v.step, 0);
      wl = 0;
    end
    repeat (2) @(negedge clk);
    start_now(v.len);
    chk("err_pulse", tx_err, v.exp_err);
    chk("first_en", gmii_tx_en, v.exp_done);
    chk("first_txd", gmii_txd, v.exp_done ? 8'h55 : 8'h00);
    wait_ready(4000);
    repeat (3) @(negedge clk);
    chk("done_cnt", done_cnt, v.exp_done);
    chk("err_cnt", err_cnt, v.exp_err);
    chk("pop_cnt", pop_cnt, v.exp_done ? v.len : 0);
    chk("en_cycles", en_cnt, wl);
    chk("busy_cycles", busy_cnt, v.exp_done ? wl + 11 : 0);
    chk("er_cnt", er_cnt, 0);
    chk("sb_empty", exp_q.size(), 0);
    fifo_q.delete();
  endtask

  vec_t vecs[8];

  initial begin
    int wl, n;
    vec_t v;
    vecs[0] = '{9,    8'h31, 8'h01, 1'b0, 1'b1};
    vecs[1] = '{0,    8'h10, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{1515, 8'h20, 8'h01, 1'b1, 1'b0};
    vecs[3] = '{1,    8'hAA, 8'h00, 1'b0, 1'b1};
    vecs[4] = '{64,   8'h00, 8'h03, 1'b0, 1'b1};
    vecs[5] = '{59,   8'h5A, 8'h11, 1'b0, 1'b1};
    vecs[6] = '{60,   8'hE0, 8'h07, 1'b0, 1'b1};
    vecs[7] = '{1514, 8'h01, 8'h01, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_ready", tx_ready, 1);
    chk("rst_tx_en", gmii_tx_en, 0);
    chk("rst_tx_er", gmii_tx_er, 0);
    chk("rst_txd", gmii_txd, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_err", tx_err, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
`ifndef ETH_MAC_TX_PAD_EN
      if (i == 0) chk_fcs_123();
`endif
    end

    // Underrun: 40 of 100 bytes present, the rest arrive 20 cycles after the error.
    @(negedge clk);
    clear_counts();
    load_fifo(40, 8'h10, 8'h01, 0);
    for (int i = 0; i < 7; i++) exp_q.push_back(mk(1'b0, 8'h55));
    exp_q.push_back(mk(1'b0, 8'hD5));
    for (int i = 0; i < 40; i++) exp_q.push_back(mk(1'b0, pay(8'h10, 8'h01, i)));
    exp_q.push_back(mk(1'b1, 8'h00));
    repeat (2) @(negedge clk);
    start_now(100);
    n = 0;
    while (err_cnt == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("underrun_timeout", (n >= 300), 0);
    repeat (20) @(negedge clk);
    load_fifo(60, 8'h10, 8'h01, 40);
    wait_ready(1000);
    repeat (3) @(negedge clk);
    chk("ur_err_cnt", err_cnt, 1);
    chk("ur_er_cycles", er_cnt, 1);
    chk("ur_er_with_err", er_err_cnt, 1);
    chk("ur_done_cnt", done_cnt, 0);
    chk("ur_pops", pop_cnt, 100);
    chk("ur_en_cycles", en_cnt, 49);
    chk("ur_sb_empty", exp_q.size(), 0);
    v = '{20, 8'h3C, 8'h02, 1'b0, 1'b1};
    run_vec(v);

    // Back-to-back 64-byte frames, second start on the first ready cycle.
    @(negedge clk);
    clear_counts();
    load_fifo(64, 8'h40, 8'h05, 0);
    load_fifo(64, 8'h80, 8'h07, 0);
    expect_frame(64, 8'h40, 8'h05, wl);
    expect_frame(64, 8'h80, 8'h07, wl);
    repeat (2) @(negedge clk);
    start_now(64);
    wait_ready(1000);
    start_now(64);
    wait_ready(1000);
    repeat (3) @(negedge clk);
    chk("b2b_gap", last_gap, 12);
    chk("b2b_done_cnt", done_cnt, 2);
    chk("b2b_pops", pop_cnt, 128);
    chk("b2b_en_cycles", en_cnt, 2 * wl);
    chk("b2b_sb_empty", exp_q.size(), 0);

    // Reset in the middle of DATA, then a clean frame.
    @(negedge clk);
    clear_counts();
    load_fifo(30, 8'hC0, 8'h01, 0);
    expect_frame(30, 8'hC0, 8'h01, wl);
    repeat (2) @(negedge clk);
    start_now(30);
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_tx_en", gmii_tx_en, 0);
    chk("arst_txd", gmii_txd, 0);
    chk("arst_rd_en", fifo_rd_en, 0);
    chk("arst_ready", tx_ready, 1);
    exp_q.delete();
    fifo_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("post_rst_ready", tx_ready, 1);
    run_vec(vecs[0]);
`ifndef ETH_MAC_TX_PAD_EN
    chk_fcs_123();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
